// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             b_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic             load, step, last;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             br, d_bit, br_next;
    logic [CW-1:0]    cnt;

    full_sub u_cell (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (br),
        .d   (d_bit),
        .bout(br_next)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: if (start) begin
                load       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                step = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                // back-to-back: a start seen while done is high reloads directly
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            b_out  <= 1'b0;
        end else if (load) begin
            a_sr <= a;
            b_sr <= b;
            br   <= b_in;
            cnt  <= '0;
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            br     <= br_next;
            if (last) begin
                diff  <= {d_bit, res_sr[WIDTH-1:1]};
                b_out <= br_next;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // operand sign bits are shifted out, so keep a copy for the overflow term
    logic a_msb, b_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (step && last) begin
            ovf <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
        end
    end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         b_in = 1'b0;
    logic         busy, done, b_out;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .b_in (b_in),
        .busy (busy),
        .done (done),
        .diff (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf  (ovf),
`endif
        .b_out(b_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // {borrow, diff} from plain 9-bit arithmetic
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    endfunction

    logic [W-1:0] cur_a, cur_b;
    logic         cur_bi;

    task automatic check_result(input string tag);
        logic [W:0] r;
        r = model(cur_a, cur_b, cur_bi);
        chk({tag, ".diff"}, 32'(diff), 32'(r[W-1:0]));
        chk({tag, ".b_out"}, 32'(b_out), 32'(r[W]));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf),
            32'((cur_a[W-1] ^ cur_b[W-1]) & (cur_a[W-1] ^ r[W-1])));
`endif
    endtask

    // Call with time just after a posedge where start was accepted; waits for done.
    // Returns edges taken; optionally pokes start mid-operation; diff must hold.
    task automatic wait_done(input bit poke, input logic [W-1:0] held, output int n);
        bit bad;
        bad = 1'b0;
        n = 0;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
        while (n < 40) begin
            if (busy !== 1'b1 || done !== 1'b0 || diff !== held) bad = 1'b1;
            start = poke && (n == 3 || n == 5);
            @(posedge clk); #1;
            n++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        chk("shift_phase_flags", 32'(bad), 32'd0);
    endtask

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        @(negedge clk);
        a = x; b = y; b_in = bi; start = 1'b1;
        cur_a = x; cur_b = y; cur_bi = bi;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic bi, input bit poke);
        int n;
        logic [W-1:0] held;
        held = diff;
        launch(x, y, bi);
        wait_done(poke, held, n);
        chk({tag, ".latency"}, 32'(n), 32'(W));
        check_result(tag);
    endtask

    initial begin
        int n;
        logic [W-1:0] held;

        // async reset with no clock edge in between
        #2 rst = 1'b1;
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.diff", 32'(diff), 32'd0);
        chk("rst.b_out", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk); rst = 1'b0;

        run_op("basic", 8'h35, 8'h12, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        run_op("underflow", 8'h00, 8'h01, 1'b0, 1'b0);
        run_op("borrow_in", 8'h10, 8'h0F, 1'b1, 1'b0);
        run_op("signed_ovf", 8'h80, 8'h01, 1'b0, 1'b0);

        // start pokes during SHIFT, then start held in DONE for back-to-back
        run_op("poked", 8'hC3, 8'h3C, 1'b1, 1'b1);
        held = diff;
        a = 8'h7F; b = 8'hFF; b_in = 1'b1; start = 1'b1;
        cur_a = 8'h7F; cur_b = 8'hFF; cur_bi = 1'b1;
        @(posedge clk); #1;
        wait_done(1'b0, held, n);
        chk("b2b.spacing", 32'(n + 1), 32'(W + 1));
        check_result("b2b");

        // reset after three bits aborts the operation
        launch(8'h55, 8'h11, 1'b0);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.diff", 32'(diff), 32'd0);
        chk("abort.busy", 32'(busy), 32'd0);
        @(negedge clk); rst = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            repeat (12) begin
                @(posedge clk); #1;
                if (done === 1'b1 || diff !== 8'h00) seen = 1'b1;
            end
            chk("abort.quiet", 32'(seen), 32'd0);
        end
        run_op("after_abort", 8'hA5, 8'h5A, 1'b0, 1'b0);

        // randomized operations, some with idle gaps
        for (int i = 0; i < 24; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        chk("rand_boundary_max", 32'(model(8'hFF, 8'h00, 1'b0)), 32'h0FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
